// File: rtl/ram_bist_pkg.sv
// Shared state type, error counter width, read latency helper and data
// pattern for the RAM BIST sequencer and its checker.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } bist_state_e;

  localparam int ERR_CNT_W = 16;

  function automatic int calc_lat(input string output_reg);
    return (output_reg == "TRUE") ? 2 : 1;
  endfunction

  // Callers size-cast the result, which zero-extends or truncates both the
  // address and the seed to the RAM word width.
  function automatic logic [63:0] expected(input logic [63:0] addr,
                                           input logic [63:0] seed,
                                           input logic        inv);
    logic [63:0] word;
    word = addr ^ seed;
    return inv ? ~word : word;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-return checker: tracks each issued read for LAT cycles, compares the
// returning word with the pattern and keeps the error count and first address.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int          DATA_WIDTH   = 8,
  parameter int          ADDR_WIDTH   = 9,
  parameter int          LAT          = 2,
  parameter logic [63:0] PATTERN_SEED = 64'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_issue,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_inv,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [ERR_CNT_W-1:0]  o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

  logic                  r_vld  [LAT];
  logic [ADDR_WIDTH-1:0] r_addr [LAT];
  logic                  r_inv  [LAT];
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  w_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_inv[i]  <= 1'b0;
      end
    end else begin
      r_vld[0]  <= i_issue;
      r_addr[0] <= i_addr;
      r_inv[0]  <= i_inv;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
        r_inv[i]  <= r_inv[i-1];
      end
    end
  end

  assign w_mismatch = r_vld[LAT-1] &&
    (i_rdata != DATA_WIDTH'(expected(64'(r_addr[LAT-1]), PATTERN_SEED, r_inv[LAT-1])));

  // A zero count means no mismatch has been seen yet, so it marks the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (i_clear) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (w_mismatch) begin
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
      if (r_err_count == '0) begin
        r_first_err_addr <= r_addr[LAT-1];
      end
    end
  end

  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/ram_bist_sequencer.sv
// RAM BIST sequencer: writes the pattern to every address, reads it all back
// and reports the result. Define RAM_BIST_INVERT_PASS_EN for a second,
// inverted-pattern write/read pass.
module ram_bist_sequencer
  import ram_bist_pkg::*;
#(
  parameter int          DATA_WIDTH   = 8,
  parameter int          ADDR_WIDTH   = 9,
  parameter string       OUTPUT_REG   = "TRUE",
  parameter logic [63:0] PATTERN_SEED = 64'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int                    LAT        = calc_lat(OUTPUT_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_DRAIN = ADDR_WIDTH'(LAT - 1);

  bist_state_e           r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr, w_next_addr;
  logic                  r_start;
  logic                  w_accept, w_busy, w_inv, w_we, w_re;
  logic [ERR_CNT_W-1:0]  w_err_count;

`ifdef RAM_BIST_INVERT_PASS_EN
  logic r_inv, w_next_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inv <= 1'b0;
    else        r_inv <= w_next_inv;
  end

  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  // Requests are registered with busy masking, so a start seen mid-test is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 1'b0;
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_start <= start & ~w_busy;
      r_state <= w_next_state;
      r_addr  <= w_next_addr;
    end
  end

  // r_addr doubles as the DRAIN wait counter.
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    w_accept     = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
    w_next_inv   = r_inv;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (r_start) begin
          w_accept     = 1'b1;
          w_next_state = WRITE;
          w_next_addr  = '0;
`ifdef RAM_BIST_INVERT_PASS_EN
          w_next_inv   = 1'b0;
`endif
        end
      end
      WRITE: begin
        w_next_addr = r_addr + ADDR_WIDTH'(1);
        if (r_addr == LAST_ADDR) begin
          w_next_state = READ;
          w_next_addr  = '0;
        end
      end
      READ: begin
        w_next_addr = r_addr + ADDR_WIDTH'(1);
        if (r_addr == LAST_ADDR) begin
          w_next_state = DRAIN;
          w_next_addr  = '0;
        end
      end
      DRAIN: begin
        w_next_addr = r_addr + ADDR_WIDTH'(1);
        if (r_addr == LAST_DRAIN) begin
          w_next_addr = '0;
`ifdef RAM_BIST_INVERT_PASS_EN
          if (!r_inv) begin
            w_next_state = WRITE;
            w_next_inv   = 1'b1;
          end else begin
            w_next_state = DONE;
          end
`else
          w_next_state = DONE;
`endif
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_we   = (r_state == WRITE);
  assign w_re   = (r_state == READ);
  assign w_busy = w_we | w_re | (r_state == DRAIN);

  assign busy      = w_busy;
  assign done      = (r_state == DONE);
  assign pass      = done & (w_err_count == '0);
  assign err_count = w_err_count;

  assign ram_we    = w_we;
  assign ram_waddr = w_we ? r_addr : '0;
  assign ram_wdata = w_we ? DATA_WIDTH'(expected(64'(r_addr), PATTERN_SEED, w_inv)) : '0;
  assign ram_re    = w_re;
  assign ram_raddr = w_re ? r_addr : '0;

  ram_bist_checker #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LAT         (LAT),
    .PATTERN_SEED(PATTERN_SEED)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_accept),
    .i_issue         (w_re),
    .i_addr          (r_addr),
    .i_inv           (w_inv),
    .i_rdata         (ram_rdata),
    .o_err_count     (w_err_count),
    .o_first_err_addr(first_err_addr)
  );

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Bench for ram_bist_sequencer: two instances (registered and unregistered RAM
// output) against behavioural RAMs, checked every cycle by a schedule model.
module tb_ram_bist_sequencer;

  localparam int D = 16;
`ifdef RAM_BIST_INVERT_PASS_EN
  localparam int          PASSES     = 2;
  localparam int          LAT_A_EXP  = 69;
  localparam int          LAT_B_EXP  = 67;
  localparam logic [7:0]  MEM3_EXP   = 8'h59;
  localparam int          FAULT5_ERR = 2;
  localparam int          STUCK_ERR  = 1;
  localparam int          STUCK_FIRST = 2;
`else
  localparam int          PASSES     = 1;
  localparam int          LAT_A_EXP  = 35;
  localparam int          LAT_B_EXP  = 34;
  localparam logic [7:0]  MEM3_EXP   = 8'hA6;
  localparam int          FAULT5_ERR = 1;
  localparam int          STUCK_ERR  = 0;
  localparam int          STUCK_FIRST = 0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic        busyA, doneA, passA, weA, reA, busyB, doneB, passB, weB, reB;
  logic [15:0] errA, errB;
  logic [3:0]  firstA, waddrA, raddrA, firstB, waddrB, raddrB;
  logic [7:0]  wdataA, rdataA, wdataB, rdataB, regA;
  logic [7:0]  memA [16];
  logic [7:0]  memB [16];
  logic [63:0] actA, actB;

  int compared = 0;
  int mismatched = 0;
  int faultMode = 0;
  int modelK [2];
  int modelErr [2];
  int modelFirst [2];

  ram_bist_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("TRUE"), .PATTERN_SEED(64'hA5)) dutA (
    .clk(clk), .rst_n(rstN), .start(start), .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .first_err_addr(firstA), .ram_wdata(wdataA), .ram_waddr(waddrA),
    .ram_we(weA), .ram_raddr(raddrA), .ram_re(reA), .ram_rdata(rdataA));

  ram_bist_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("FALSE"), .PATTERN_SEED(64'hA5)) dutB (
    .clk(clk), .rst_n(rstN), .start(start), .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .first_err_addr(firstB), .ram_wdata(wdataB), .ram_waddr(waddrB),
    .ram_we(weB), .ram_raddr(raddrB), .ram_re(reB), .ram_rdata(rdataB));

  assign actA = {23'b0, busyA, doneA, passA, weA, waddrA, wdataA, reA, raddrA, errA, firstA};
  assign actB = {23'b0, busyB, doneB, passB, weB, waddrB, wdataB, reB, raddrB, errB, firstB};

  function automatic logic [7:0] pattern(input int a, input int p);
    return 8'(a) ^ 8'hA5 ^ ((p != 0) ? 8'hFF : 8'h00);
  endfunction

  // Fault 1: address 5 always stores 0; fault 2: bit 0 of address 2 stuck at 1.
  function automatic logic [7:0] applyFault(input int mode, input int a, input logic [7:0] d);
    if (mode == 1 && a == 5) return 8'h00;
    if (mode == 2 && a == 2) return d | 8'h01;
    return d;
  endfunction

  always @(posedge clk) begin
    if (weA) memA[waddrA] <= applyFault(faultMode, int'(waddrA), wdataA);
    if (reA) regA <= memA[raddrA];
    rdataA <= regA;
  end

  always @(posedge clk) begin
    if (weB) memB[waddrB] <= wdataB;
    if (reB) rdataB <= memB[raddrB];
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int doneK(input int l);
    return PASSES * (2 * D + l) + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Error tally from the data each pass writes versus what the faulty RAM keeps.
  task automatic modelAccept(input int d);
    logic [7:0] w;
    modelK[d] = 0;
    modelErr[d] = 0;
    modelFirst[d] = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < D; a++) begin
        w = pattern(a, p);
        if (d == 0 && applyFault(faultMode, a, w) != w) begin
          if (modelErr[d] == 0) modelFirst[d] = a;
          modelErr[d]++;
        end
      end
    end
  endtask

  // k counts edges since the edge that sampled start; k<0 means idle after reset.
  function automatic logic [63:0] expectVec(input int k, input int l, input int err, input int first,
                                            output logic [63:0] mask);
    logic busy, dn, ps, we, re;
    logic [3:0] wa, ra, f;
    logic [7:0] wd;
    logic [15:0] e;
    int j, p;
    busy = 0; dn = 0; ps = 0; we = 0; re = 0;
    wa = 0; ra = 0; f = 0; wd = 0; e = 0;
    mask = '1;
    if (k >= doneK(l)) begin
      dn = 1;
      ps = (err == 0);
      e = 16'(err);
      f = 4'(first);
    end else if (k > 0) begin
      busy = 1;
      j = (k - 1) % (2 * D + l);
      p = (k - 1) / (2 * D + l);
      if (j < D) begin
        we = 1; wa = 4'(j); wd = pattern(j, p);
      end else if (j < 2 * D) begin
        re = 1; ra = 4'(j - D);
      end
      mask[19:0] = '0;
    end
    return {23'b0, busy, dn, ps, we, wa, wd, re, ra, e, f};
  endfunction

  always @(negedge rstN) begin
    modelK[0] = -1;
    modelK[1] = -1;
  end

  always @(posedge clk) begin
    if (rstN) begin
      for (int d = 0; d < 2; d++) begin
        if (start && !(modelK[d] >= 0 && modelK[d] < doneK(latOf(d)))) modelAccept(d);
        else if (modelK[d] >= 0 && modelK[d] < 100000) modelK[d]++;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] expV, msk, act;
    for (int d = 0; d < 2; d++) begin
      if (modelK[d] != 0) begin
        expV = expectVec(modelK[d], latOf(d), modelErr[d], modelFirst[d], msk);
        act = (d == 0) ? actA : actB;
        checkOutput($sformatf("outputs dut%0d k=%0d", d, modelK[d]), act & msk, expV & msk);
      end
    end
  end

  task automatic applyStimulus(input bit extraPulses, output int latA, output int latB);
    latA = -1;
    latB = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 300 && latA < 0; n++) begin
      @(posedge clk); #1;
      if (doneA && latA < 0) latA = n;
      if (doneB && latB < 0) latB = n;
      @(negedge clk); start = extraPulses && (n == 3 || n == 5);
    end
    start = 1'b0;
    checkOutput("done within bound", 64'(latA >= 0), 64'd1);
  endtask

  initial begin
    int la, lb;
    bit found;
    modelK[0] = -1;
    modelK[1] = -1;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busyA), 64'd0);
    checkOutput("reset done", 64'(doneA), 64'd0);
    checkOutput("reset outputs", actA, 64'd0);
    rstN = 1'b1;

    $display("[TB] clean run");
    applyStimulus(1'b0, la, lb);
    checkOutput("clean latency A", 64'(la), 64'(LAT_A_EXP));
    checkOutput("clean latency B", 64'(lb), 64'(LAT_B_EXP));
    checkOutput("clean pass A", 64'(passA), 64'd1);
    checkOutput("clean pass B", 64'(passB), 64'd1);
    checkOutput("clean err A", 64'(errA), 64'd0);
    checkOutput("clean first A", 64'(firstA), 64'd0);
    checkOutput("clean mem3", 64'(memA[3]), 64'(MEM3_EXP));
    checkOutput("model pattern 3", 64'(pattern(3, 0)), 64'hA6);

    $display("[TB] address 5 forced to zero");
    faultMode = 1;
    applyStimulus(1'b0, la, lb);
    checkOutput("fault5 model err", 64'(modelErr[0]), 64'(FAULT5_ERR));
    checkOutput("fault5 err", 64'(errA), 64'(FAULT5_ERR));
    checkOutput("fault5 first", 64'(firstA), 64'd5);
    checkOutput("fault5 pass", 64'(passA), 64'd0);
    checkOutput("fault5 B unaffected", 64'(passB), 64'd1);

    $display("[TB] address 2 bit 0 stuck at 1");
    faultMode = 2;
    applyStimulus(1'b0, la, lb);
    checkOutput("stuck err", 64'(errA), 64'(STUCK_ERR));
    checkOutput("stuck first", 64'(firstA), 64'(STUCK_FIRST));
    checkOutput("stuck pass", 64'(passA), 64'(STUCK_ERR == 0));
    faultMode = 0;

    $display("[TB] reset during read of address 7");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (reA && raddrA == 4'd7) found = 1;
    end
    checkOutput("reached read addr 7", 64'(found), 64'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset outputs A", actA, 64'd0);
    checkOutput("midreset outputs B", actB, 64'd0);
    @(negedge clk); rstN = 1'b1;
    applyStimulus(1'b0, la, lb);
    checkOutput("after reset latency", 64'(la), 64'(LAT_A_EXP));
    checkOutput("after reset pass", 64'(passA), 64'd1);

    $display("[TB] start pulses while busy");
    applyStimulus(1'b1, la, lb);
    checkOutput("busy start latency", 64'(la), 64'(LAT_A_EXP));
    checkOutput("busy start pass", 64'(passA), 64'd1);

    $display("[TB] start held high");
    @(negedge clk); start = 1'b1;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (busyA) found = 1;
    end
    checkOutput("held start begins", 64'(found), 64'd1);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (doneA) found = 1;
    end
    checkOutput("held start done", 64'(found), 64'd1);
    found = 0;
    for (int n = 0; n < 3 && !found; n++) begin
      @(negedge clk);
      if (busyA && !doneA) found = 1;
    end
    checkOutput("held start restarts", 64'(found), 64'd1);
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (doneA) found = 1;
    end
    checkOutput("held restart done", 64'(found), 64'd1);
    checkOutput("held restart pass", 64'(passA), 64'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
